// File: rtl/cronometro_pkg.sv
// Shared types and constants for the cronometro stopwatch controller.
package cronometro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_t;

    localparam logic [2:0] DEZ_MAX = 3'd5;
    localparam logic [3:0] UNI_MAX = 4'd9;

    function automatic logic is_counting(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

endpackage

// File: rtl/bcd_mod60.sv
// Two-digit BCD counter 00..59; clr wins over en, carry flags the 59->00 step.
module bcd_mod60
    import cronometro_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    output logic [2:0] dez,
    output logic [3:0] uni,
    output logic       carry
);

    logic at_max;

    assign at_max = (dez == DEZ_MAX) && (uni == UNI_MAX);
    assign carry  = en && !clr && at_max;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            dez <= '0;
            uni <= '0;
        end else if (en) begin
            if (uni == UNI_MAX) begin
                uni <= '0;
                if (dez == DEZ_MAX) begin
                    dez <= '0;
                end else begin
                    dez <= dez + 3'd1;
                end
            end else begin
                uni <= uni + 4'd1;
            end
        end
    end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP FSM with BCD seconds and lap freeze.
// Define CRONOMETRO_MINUTES_EN to add a minutes counter and min_dez/min_uni ports.
module cronometro_ctrl
    import cronometro_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [2:0] dez,
    output logic [3:0] uni,
    output logic       running,
    output logic       wrap
`ifdef CRONOMETRO_MINUTES_EN
    ,
    output logic [2:0] min_dez,
    output logic [3:0] min_uni
`endif
);

    state_t     state;
    state_t     state_next;
    logic       lap_capture;
    logic       count_en;
    logic       wrap_next;

    logic [2:0] sec_dez;
    logic [3:0] sec_uni;
    logic       sec_carry;
    logic [2:0] lap_dez;
    logic [3:0] lap_uni;

    // Counting follows the registered state, not the transition on the same edge.
    assign count_en = tick && is_counting(state);

    bcd_mod60 u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (count_en),
        .clr   (clear),
        .dez   (sec_dez),
        .uni   (sec_uni),
        .carry (sec_carry)
    );

`ifdef CRONOMETRO_MINUTES_EN
    logic [2:0] mdez;
    logic [3:0] muni;
    logic       min_carry;
    logic [2:0] lap_min_dez;
    logic [3:0] lap_min_uni;

    bcd_mod60 u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (sec_carry),
        .clr   (clear),
        .dez   (mdez),
        .uni   (muni),
        .carry (min_carry)
    );

    assign wrap_next = min_carry;
`else
    assign wrap_next = sec_carry;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority clear > start_stop > lap is encoded by the if/else order.
    always_comb begin
        state_next  = state;
        lap_capture = 1'b0;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_stop) state_next = RUN;
                end
                RUN: begin
                    if (start_stop) begin
                        state_next = PAUSE;
                    end else if (lap) begin
                        state_next  = LAP;
                        lap_capture = 1'b1;
                    end
                end
                LAP: begin
                    if (start_stop) begin
                        state_next = PAUSE;
                    end else if (lap) begin
                        state_next = RUN;
                    end
                end
                PAUSE: begin
                    if (start_stop) state_next = RUN;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            lap_dez <= '0;
            lap_uni <= '0;
        end else if (lap_capture) begin
            lap_dez <= sec_dez;
            lap_uni <= sec_uni;
        end
    end

`ifdef CRONOMETRO_MINUTES_EN
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            lap_min_dez <= '0;
            lap_min_uni <= '0;
        end else if (lap_capture) begin
            lap_min_dez <= mdez;
            lap_min_uni <= muni;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

    assign running = is_counting(state);

    always_comb begin
        dez = sec_dez;
        uni = sec_uni;
`ifdef CRONOMETRO_MINUTES_EN
        min_dez = mdez;
        min_uni = muni;
`endif
        if (state == LAP) begin
            dez = lap_dez;
            uni = lap_uni;
`ifdef CRONOMETRO_MINUTES_EN
            min_dez = lap_min_dez;
            min_uni = lap_min_uni;
`endif
        end
    end

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed self-checking bench for cronometro_ctrl (both macro builds).
module tb_cronometro_ctrl;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [2:0] dez;
    logic [3:0] uni;
    logic       running;
    logic       wrap;
`ifdef CRONOMETRO_MINUTES_EN
    logic [2:0] min_dez;
    logic [3:0] min_uni;
    localparam bit MIN_EN = 1'b1;
`else
    localparam bit MIN_EN = 1'b0;
`endif

    int vectors;
    int miscompares;

    cronometro_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .dez        (dez),
        .uni        (uni),
        .running    (running),
        .wrap       (wrap)
`ifdef CRONOMETRO_MINUTES_EN
        ,
        .min_dez    (min_dez),
        .min_uni    (min_uni)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge with the given input pulses; returns 1 time unit after the edge.
    task automatic cyc(input logic t, input logic ss, input logic lp, input logic cl);
        tick = t; start_stop = ss; lap = lp; clear = cl;
        @(posedge clk); #1;
        tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    endtask

    function automatic logic [6:0] bcd(input int k);
        logic [2:0] d;
        logic [3:0] u;
        d = 3'(k / 10);
        u = 4'(k % 10);
        return {d, u};
    endfunction

    task automatic test_reset;
        rst = 1'b0; tick = 1'b1; start_stop = 1'b1; lap = 1'b1; clear = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if ({dez, uni, running, wrap} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_state got %b exp %b", {dez, uni, running, wrap}, 9'b0);
        end
        tick = 1'b0; start_stop = 1'b0; lap = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_idle_ticks;
        for (int k = 1; k <= 70; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            vectors++;
            if ({dez, uni, running, wrap} !== 9'b0) begin
                miscompares++;
                $display("FAIL idle_tick_%0d got %b exp %b", k, {dez, uni, running, wrap}, 9'b0);
            end
        end
    endtask

    task automatic test_full_minute;
        logic exp_wrap;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {7'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL start_run got %b exp %b", {dez, uni, running}, {7'b0, 1'b1});
        end
        for (int k = 1; k <= 60; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            exp_wrap = !MIN_EN && (k == 60);
            vectors++;
            if ({dez, uni, wrap} !== {bcd(k % 60), exp_wrap}) begin
                miscompares++;
                $display("FAIL minute_tick_%0d got %b exp %b", k, {dez, uni, wrap}, {bcd(k % 60), exp_wrap});
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, wrap} !== 8'b0) begin
            miscompares++;
            $display("FAIL wrap_one_cycle got %b exp %b", {dez, uni, wrap}, 8'b0);
        end
    endtask

    task automatic test_lap;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(12), 1'b1}) begin
            miscompares++;
            $display("FAIL lap_enter got %b exp %b", {dez, uni, running}, {bcd(12), 1'b1});
        end
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            vectors++;
            if ({dez, uni, running} !== {bcd(12), 1'b1}) begin
                miscompares++;
                $display("FAIL lap_hold_%0d got %b exp %b", k, {dez, uni, running}, {bcd(12), 1'b1});
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(17), 1'b1}) begin
            miscompares++;
            $display("FAIL lap_release got %b exp %b", {dez, uni, running}, {bcd(17), 1'b1});
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni} !== bcd(18)) begin
            miscompares++;
            $display("FAIL lap_resume got %b exp %b", {dez, uni}, bcd(18));
        end
    endtask

    task automatic test_pause;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 34; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(34), 1'b0}) begin
            miscompares++;
            $display("FAIL pause_enter got %b exp %b", {dez, uni, running}, {bcd(34), 1'b0});
        end
        for (int k = 1; k <= 10; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            vectors++;
            if ({dez, uni, running} !== {bcd(34), 1'b0}) begin
                miscompares++;
                $display("FAIL pause_hold_%0d got %b exp %b", k, {dez, uni, running}, {bcd(34), 1'b0});
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(35), 1'b1}) begin
            miscompares++;
            $display("FAIL pause_resume got %b exp %b", {dez, uni, running}, {bcd(35), 1'b1});
        end
    endtask

    task automatic test_coincident;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 59; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni} !== bcd(59)) begin
            miscompares++;
            $display("FAIL reach_59 got %b exp %b", {dez, uni}, bcd(59));
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        vectors++;
        if ({dez, uni, running, wrap} !== 9'b0) begin
            miscompares++;
            $display("FAIL clear_tick_ss got %b exp %b", {dez, uni, running, wrap}, 9'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, running, wrap} !== 9'b0) begin
            miscompares++;
            $display("FAIL clear_settle got %b exp %b", {dez, uni, running, wrap}, 9'b0);
        end
    endtask

    task automatic test_priority;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if ({dez, uni, running} !== 8'b0) begin
            miscompares++;
            $display("FAIL idle_lap_ignored got %b exp %b", {dez, uni, running}, 8'b0);
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(4), 1'b0}) begin
            miscompares++;
            $display("FAIL run_ss_over_lap got %b exp %b", {dez, uni, running}, {bcd(4), 1'b0});
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(4), 1'b1}) begin
            miscompares++;
            $display("FAIL pause_to_run_tick got %b exp %b", {dez, uni, running}, {bcd(4), 1'b1});
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(4), 1'b1}) begin
            miscompares++;
            $display("FAIL lap_latch_04 got %b exp %b", {dez, uni, running}, {bcd(4), 1'b1});
        end
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        vectors++;
        if ({dez, uni, running} !== {bcd(6), 1'b0}) begin
            miscompares++;
            $display("FAIL lap_ss_to_pause got %b exp %b", {dez, uni, running}, {bcd(6), 1'b0});
        end
    endtask

    task automatic test_reset_mid;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        vectors++;
        if ({dez, uni, running, wrap} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_mid got %b exp %b", {dez, uni, running, wrap}, 9'b0);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({dez, uni, running} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_mid_idle got %b exp %b", {dez, uni, running}, 8'b0);
        end
    endtask

`ifdef CRONOMETRO_MINUTES_EN
    task automatic test_minutes;
        int early_wraps;
        early_wraps = 0;
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3600; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (k < 3600 && wrap) early_wraps++;
            if (k == 60) begin
                vectors++;
                if ({min_dez, min_uni, dez, uni} !== {bcd(1), bcd(0)}) begin
                    miscompares++;
                    $display("FAIL min_01_00 got %b exp %b", {min_dez, min_uni, dez, uni}, {bcd(1), bcd(0)});
                end
            end
            if (k == 3599) begin
                vectors++;
                if ({min_dez, min_uni, dez, uni} !== {bcd(59), bcd(59)}) begin
                    miscompares++;
                    $display("FAIL min_59_59 got %b exp %b", {min_dez, min_uni, dez, uni}, {bcd(59), bcd(59)});
                end
            end
            if (k == 3600) begin
                vectors++;
                if ({min_dez, min_uni, dez, uni, wrap} !== 15'b1) begin
                    miscompares++;
                    $display("FAIL min_rollover got %b exp %b", {min_dez, min_uni, dez, uni, wrap}, 15'b1);
                end
            end
        end
        vectors++;
        if (early_wraps !== 0) begin
            miscompares++;
            $display("FAIL min_early_wraps got %0d exp 0", early_wraps);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (wrap !== 1'b0) begin
            miscompares++;
            $display("FAIL min_wrap_one_cycle got %b exp 0", wrap);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0; tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        test_reset();
        test_idle_ticks();
        test_full_minute();
        test_lap();
        test_pause();
        test_coincident();
        test_priority();
        test_reset_mid();
`ifdef CRONOMETRO_MINUTES_EN
        test_minutes();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
